// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: state encoding,
// default operand width and bit-counter sizing.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    // A counter of width 1 is still needed when WIDTH is 2.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Gate-level full adder; the one arithmetic cell shared by the serial
// subtractor here and the planned serial adder.
module fa_cell (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    logic axb;
    logic gen;
    logic prop;

    xor u_x1 (axb, a, b);
    xor u_x2 (sum, axb, cin);
    and u_a1 (gen, a, b);
    and u_a2 (prop, axb, cin);
    or  u_o1 (cout, gen, prop);

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial subtractor: diff_out = sum_in - addend_in computed LSB-first as
// sum_in + ~addend_in + 1 through a single full-adder cell over WIDTH cycles.
module serial_sub_unit
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] addend_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic [1:0]       dbg_state
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;

    fa_cell u_fa (
        .sum  (fa_sum),
        .cout (fa_cout),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q)
    );

    // Handshake: start is taken on any edge where busy is low (IDLE or the
    // DONE cycle); while busy is high start is ignored, nothing is queued.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                accept = start;
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                r_d     = {fa_sum, r_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    diff_d   = {fa_sum, r_q[WIDTH-1:1]};
                    borrow_d = ~fa_cout;
                end
            end
            DONE: begin
                state_d = IDLE;
                accept  = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Two's-complement subtraction: invert the subtrahend, carry-in of 1.
        if (accept) begin
            state_d = SHIFT;
            a_d     = sum_in;
            b_d     = ~addend_in;
            carry_d = 1'b1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_serial_sub_unit.sv
// Self-checking bench for serial_sub_unit: directed cases, start handling,
// back-to-back operation, reset abort and randomized operands.
module tb_serial_sub_unit;

    localparam int W   = 8;
    localparam int LAT = W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] sum_in;
    logic [W-1:0] addend_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff_out;
    logic         borrow_out;
    logic [1:0]   dbg_state;

    logic [W:0]   exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    always #5 clk = ~clk;

    serial_sub_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sum_in     (sum_in),
        .addend_in  (addend_in),
        .busy       (busy),
        .done       (done),
        .diff_out   (diff_out),
        .borrow_out (borrow_out),
        .dbg_state  (dbg_state)
    );

    // Reference: {borrow, difference} from plain integer arithmetic.
    function automatic logic [W:0] ref_model(input logic [W-1:0] s, input logic [W-1:0] a);
        int d;
        d = (int'(s) - int'(a) + (1 << W)) % (1 << W);
        return {(a > s), W'(d)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair for exactly one accepting edge, then scrambles inputs.
    task automatic drive_start(input logic [W-1:0] s, input logic [W-1:0] a);
        start     = 1'b1;
        sum_in    = s;
        addend_in = a;
        tick();
        start     = 1'b0;
        sum_in    = W'($urandom);
        addend_in = W'($urandom);
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 3 * LAT; i++) begin
            tick();
            if (done) begin
                k = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; sum_in = 8'h5A; addend_in = 8'h23;
        tick();
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_tests++; if (diff_out !== '0) begin n_fail++; $display("FAIL reset_diff got=%h exp=00", diff_out); end
        n_tests++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored busy=%b exp=0", busy); end
    endtask

    task automatic test_directed();
        logic [W-1:0] s_tab [6] = '{8'h5A, 8'h10, 8'h00, 8'hFF, 8'h00, 8'h80};
        logic [W-1:0] a_tab [6] = '{8'h23, 8'h20, 8'h00, 8'hFF, 8'h01, 8'h01};
        logic [W:0]   exp;
        logic [W:0]   prev;
        int           got_k;
        for (int t = 0; t < 6; t++) begin
            exp  = ref_model(s_tab[t], a_tab[t]);
            prev = {borrow_out, diff_out};
            drive_start(s_tab[t], a_tab[t]);
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy_start got=%b exp=1", t, busy); end
            got_k = -1;
            for (int i = 1; i <= 3 * LAT; i++) begin
                tick();
                if (done) begin
                    got_k = i;
                    break;
                end
                n_tests++;
                if (busy !== 1'b1 || {borrow_out, diff_out} !== prev) begin
                    n_fail++;
                    $display("FAIL dir%0d_shift cyc=%0d busy=%b out=%h exp busy=1 out=%h", t, i, busy, {borrow_out, diff_out}, prev);
                end
            end
            n_tests++; if (got_k != LAT) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", t, got_k, LAT); end
            n_tests++; if (diff_out !== exp[W-1:0]) begin n_fail++; $display("FAIL dir%0d_diff got=%h exp=%h", t, diff_out, exp[W-1:0]); end
            n_tests++; if (borrow_out !== exp[W]) begin n_fail++; $display("FAIL dir%0d_borrow got=%b exp=%b", t, borrow_out, exp[W]); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_done got=%b exp=0", t, busy); end
            tick();
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0 || {borrow_out, diff_out} !== exp) begin
                n_fail++;
                $display("FAIL dir%0d_after done=%b busy=%b out=%h exp 0 0 %h", t, done, busy, {borrow_out, diff_out}, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W:0] exp;
        int         n_done;
        int         first_k;
        logic [W:0] first_res;
        exp = ref_model(8'h3C, 8'h11);
        drive_start(8'h3C, 8'h11);
        tick();
        tick();
        start = 1'b1; sum_in = 8'h99; addend_in = 8'h77;
        tick();
        start = 1'b0;
        n_done = 0; first_k = -1; first_res = '0;
        for (int k = 4; k <= 30; k++) begin
            if (done) begin
                n_done++;
                if (first_k < 0) begin first_k = k - 1; first_res = {borrow_out, diff_out}; end
            end
            tick();
        end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
        n_tests++; if (first_k != LAT) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=%0d", first_k, LAT); end
        n_tests++; if (first_res !== exp) begin n_fail++; $display("FAIL ignore_result got=%h exp=%h", first_res, exp); end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp;
        int         next_k;
        int         pulses;
        exp = ref_model(8'h80, 8'h01);
        start = 1'b1; sum_in = 8'h80; addend_in = 8'h01;
        tick();
        next_k = LAT; pulses = 0;
        for (int k = 1; k <= 44; k++) begin
            tick();
            if (done) begin
                pulses++;
                n_tests++;
                if (k != next_k || {borrow_out, diff_out} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_pulse k=%0d exp_k=%0d out=%h exp=%h", k, next_k, {borrow_out, diff_out}, exp);
                end
                next_k = next_k + LAT + 1;
            end else if (pulses > 0) begin
                n_tests++;
                if ({borrow_out, diff_out} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_hold k=%0d out=%h exp=%h", k, {borrow_out, diff_out}, exp);
                end
            end
        end
        start = 1'b0;
        n_tests++; if (pulses != 5) begin n_fail++; $display("FAIL b2b_count got=%0d exp=5", pulses); end
        tick();
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_stop busy=%b done=%b exp 0 0", busy, done); end
    endtask

    task automatic test_reset_mid();
        logic [W:0] exp;
        int         n_done;
        int         k;
        drive_start(8'h5A, 8'h23);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done); end
        n_tests++; if (diff_out !== '0) begin n_fail++; $display("FAIL rstmid_diff got=%h exp=00", diff_out); end
        n_tests++; if (borrow_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_borrow got=%b exp=0", borrow_out); end
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) n_done++;
        end
        n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d exp=0", n_done); end
        exp = ref_model(8'hC8, 8'h64);
        drive_start(8'hC8, 8'h64);
        wait_done(k);
        n_tests++; if (k != LAT) begin n_fail++; $display("FAIL rstmid_restart_latency got=%0d exp=%0d", k, LAT); end
        n_tests++; if ({borrow_out, diff_out} !== exp) begin n_fail++; $display("FAIL rstmid_restart_result got=%h exp=%h", {borrow_out, diff_out}, exp); end
    endtask

    task automatic test_random();
        logic [W-1:0] corner [3] = '{8'h00, 8'hFF, 8'h80};
        logic [W-1:0] s;
        logic [W-1:0] a;
        logic [W:0]   exp;
        int           k;
        for (int n = 0; n < 1000; n++) begin
            if (n < 9) begin
                s = corner[n / 3];
                a = corner[n % 3];
            end else begin
                s = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 2)] : W'($urandom);
                a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 2)] : W'($urandom);
            end
            exp_q.push_back(ref_model(s, a));
            drive_start(s, a);
            wait_done(k);
            exp = exp_q.pop_front();
            n_tests++;
            if (k != LAT) begin
                n_fail++;
                $display("FAIL rand%0d_latency got=%0d exp=%0d", n, k, LAT);
            end else if ({borrow_out, diff_out} !== exp) begin
                n_fail++;
                $display("FAIL rand%0d_result s=%h a=%h got=%h exp=%h", n, s, a, {borrow_out, diff_out}, exp);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sum_in = '0; addend_in = '0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
